// File: rtl/gowin_pll_ctrl_if.sv
// Mode-change request channel between a system controller and gowin_pll_ctrl.
// bad_req travels back with ready because it reports the outcome of a handshake.
interface gowin_pll_ctrl_if;
  logic       mode_req_valid;
  logic [2:0] mode_req_sel;
  logic       mode_req_ready;
  logic       bad_req;

  modport master (
    output mode_req_valid,
    output mode_req_sel,
    input  mode_req_ready,
    input  bad_req
  );

  modport slave (
    input  mode_req_valid,
    input  mode_req_sel,
    output mode_req_ready,
    output bad_req
  );
endinterface

// File: rtl/gowin_pll_ctrl.sv
// Gowin PLL sequencer: pulses PLL reset, waits for a stable lock with bounded retries,
// and applies run-time frequency-mode changes by relocking with new divider selects.
module gowin_pll_ctrl #(
  parameter int NUM_MODES           = 4,
  parameter int DEFAULT_MODE        = 0,
  parameter logic [6*NUM_MODES-1:0] MODE_IDSEL  = '0,
  parameter logic [6*NUM_MODES-1:0] MODE_FBDSEL = '0,
  parameter logic [6*NUM_MODES-1:0] MODE_ODSEL  = '0,
  parameter int RESET_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic             clkin,
  input  logic             reset,
  gowin_pll_ctrl_if.slave  req,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [5:0]       pll_idsel,
  output logic [5:0]       pll_fbdsel,
  output logic [5:0]       pll_odsel,
  output logic [2:0]       cur_mode,
  output logic             clk_ok,
  output logic             rst_out,
  output logic             fail
);

  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam int SW  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int RW  = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [1:0] ST_RESET_HOLD = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK  = 2'd1;
  localparam logic [1:0] ST_RUN        = 2'd2;
  localparam logic [1:0] ST_FAIL       = 2'd3;

  logic [1:0]     state;
  logic           lock_meta;
  logic           lock_s;
  logic [RCW-1:0] rst_cnt;
  logic [SW-1:0]  stable_cnt;
  logic [TW-1:0]  timeout_cnt;
  logic [RW-1:0]  retry_cnt;
  logic           req_in_range;
  int             sel_idx;

  assign sel_idx      = int'(req.mode_req_sel);
  assign req_in_range = sel_idx < NUM_MODES;

  // Every output is a flop; transitions update the outputs for the state being entered.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state              <= ST_RESET_HOLD;
      lock_meta          <= 1'b0;
      lock_s             <= 1'b0;
      rst_cnt            <= '0;
      stable_cnt         <= '0;
      timeout_cnt        <= '0;
      retry_cnt          <= '0;
      pll_reset          <= 1'b1;
      clk_ok             <= 1'b0;
      rst_out            <= 1'b1;
      fail               <= 1'b0;
      req.bad_req        <= 1'b0;
      req.mode_req_ready <= 1'b0;
      cur_mode           <= 3'(DEFAULT_MODE);
      pll_idsel          <= MODE_IDSEL[6*DEFAULT_MODE +: 6];
      pll_fbdsel         <= MODE_FBDSEL[6*DEFAULT_MODE +: 6];
      pll_odsel          <= MODE_ODSEL[6*DEFAULT_MODE +: 6];
    end else begin
      lock_meta   <= pll_lock;
      lock_s      <= lock_meta;
      req.bad_req <= 1'b0;
      case (state)
        ST_RESET_HOLD: begin
          if (rst_cnt == RCW'(RESET_CYCLES - 1)) begin
            state       <= ST_WAIT_LOCK;
            pll_reset   <= 1'b0;
            rst_cnt     <= '0;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // A stable lock wins over a timeout that expires on the same edge.
          if (lock_s && stable_cnt == SW'(LOCK_STABLE_CYCLES - 1)) begin
            state              <= ST_RUN;
            clk_ok             <= 1'b1;
            rst_out            <= 1'b0;
            req.mode_req_ready <= 1'b1;
            retry_cnt          <= '0;
          end else if (timeout_cnt == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            if (retry_cnt < RW'(MAX_RETRIES)) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ST_RESET_HOLD;
              rst_cnt   <= '0;
              pll_reset <= 1'b1;
            end else begin
              state              <= ST_FAIL;
              fail               <= 1'b1;
              pll_reset          <= 1'b1;
              req.mode_req_ready <= 1'b1;
            end
          end else begin
            if (!lock_s)
              stable_cnt <= '0;
            else if (stable_cnt != SW'(LOCK_STABLE_CYCLES))
              stable_cnt <= stable_cnt + 1'b1;
            if (timeout_cnt != TW'(LOCK_TIMEOUT_CYCLES))
              timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        default: begin
          // RUN and FAIL share request handling; only RUN watches for lock loss.
          if (state == ST_RUN && !lock_s) begin
            state              <= ST_RESET_HOLD;
            rst_cnt            <= '0;
            pll_reset          <= 1'b1;
            clk_ok             <= 1'b0;
            rst_out            <= 1'b1;
            req.mode_req_ready <= 1'b0;
          end else if (req.mode_req_valid && req.mode_req_ready) begin
            if (req_in_range) begin
              state              <= ST_RESET_HOLD;
              rst_cnt            <= '0;
              retry_cnt          <= '0;
              fail               <= 1'b0;
              pll_reset          <= 1'b1;
              clk_ok             <= 1'b0;
              rst_out            <= 1'b1;
              req.mode_req_ready <= 1'b0;
              cur_mode           <= req.mode_req_sel;
              pll_idsel          <= MODE_IDSEL[6*sel_idx +: 6];
              pll_fbdsel         <= MODE_FBDSEL[6*sel_idx +: 6];
              pll_odsel          <= MODE_ODSEL[6*sel_idx +: 6];
            end else begin
              req.bad_req <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/gowin_pll_ctrl.md
GOWIN_PLL_CTRL -- requirements
Module: gowin_pll_ctrl

Interface
REQ-001 Parameter NUM_MODES, default 4, number of PLL frequency modes; legal range 1..8.
REQ-002 Parameter DEFAULT_MODE, default 0, mode applied after reset.
REQ-003 Parameter MODE_IDSEL / MODE_FBDSEL / MODE_ODSEL, default all-zero, packed 6*NUM_MODES-bit tables; mode m occupies bits [6m+5:6m]; values pass through to the PLL unmodified.
REQ-004 Parameter RESET_CYCLES, default 16, PLL reset pulse length in clkin cycles (>=1).
REQ-005 Parameter LOCK_STABLE_CYCLES, default 1024, consecutive synchronised-lock cycles required before RUN (>=1).
REQ-006 Parameter LOCK_TIMEOUT_CYCLES, default 65536, WAIT_LOCK cycles before timeout (> LOCK_STABLE_CYCLES).
REQ-007 Parameter MAX_RETRIES, default 3, relock attempts after the first timeout before FAIL.
REQ-008 clkin  in  1  sole clock, PLL reference clock domain.
REQ-009 reset  in  1  asynchronous, active-high.
REQ-010 mode_req_valid  in  1  mode-change request.
REQ-011 mode_req_sel  in  3  requested mode index.
REQ-012 mode_req_ready  out  1  request accepted when valid && ready.
REQ-013 pll_lock  in  1  PLL LOCK, asynchronous to clkin.
REQ-014 pll_reset  out  1  drives PLL RESET.
REQ-015 pll_idsel, pll_fbdsel, pll_odsel  out  6 each  drive PLL IDSEL/FBDSEL/ODSEL.
REQ-016 cur_mode  out  3  mode currently applied.
REQ-017 clk_ok  out  1  PLL output stable.
REQ-018 rst_out  out  1  active-high reset for PLL-output logic; always equals !clk_ok.
REQ-019 fail  out  1  retries exhausted.
REQ-020 bad_req  out  1  one-cycle pulse on accepted out-of-range request.

Function
REQ-021 pll_lock SHALL pass a 2-flop synchroniser; all decisions use the synchronised value (lock_s).
REQ-022 The FSM SHALL have states RESET_HOLD, WAIT_LOCK, RUN, FAIL; all outputs registered.
REQ-023 RESET_HOLD: pll_reset=1 for exactly RESET_CYCLES cycles, then WAIT_LOCK with stable and timeout counters cleared.
REQ-024 WAIT_LOCK: pll_reset=0; stable counter increments while lock_s=1, clears to 0 on any lock_s=0 cycle; timeout counter increments every cycle.
REQ-025 Stable counter reaching LOCK_STABLE_CYCLES SHALL move to RUN; this takes priority over a timeout in the same cycle.
REQ-026 Timeout counter reaching LOCK_TIMEOUT_CYCLES: if retry count < MAX_RETRIES, increment retry count and enter RESET_HOLD; else enter FAIL.
REQ-027 RUN: clk_ok=1 from the first RUN cycle; retry count cleared on entry.
REQ-028 RUN with lock_s=0 for one cycle SHALL enter RESET_HOLD; clk_ok drops the next cycle; retry count stays 0.
REQ-029 FAIL: fail=1, pll_reset=1, clk_ok=0; left only by reset or an accepted valid request.
REQ-030 mode_req_ready SHALL be 1 only in RUN and FAIL.
REQ-031 Accepted request with sel < NUM_MODES: cur_mode and select outputs update on the next edge, retry count and fail clear, FSM enters RESET_HOLD (same-mode requests also relock).
REQ-032 Accepted request with sel >= NUM_MODES: bad_req pulses one cycle, mode, selects and FSM unchanged.
REQ-033 In RUN, lock loss takes priority over a simultaneous request; the request is not accepted (ready=0 the following cycle).
REQ-034 Select outputs SHALL change only on entry to RESET_HOLD via REQ-031, never while pll_reset=0.
REQ-035 Counters SHALL saturate, never wrap; widths sized from the parameters.

Reset
REQ-036 On reset assertion, immediately: state RESET_HOLD, pll_reset=1, clk_ok=0, rst_out=1, fail=0, bad_req=0, mode_req_ready=0, cur_mode=DEFAULT_MODE, selects=table[DEFAULT_MODE], counters and synchroniser 0.
REQ-037 After deassertion the RESET_CYCLES count starts at the first clkin edge; reset mid-operation aborts any sequence identically.

Verification (RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-038 pll_lock=1 constantly after reset -> pll_reset high 4 cycles; clk_ok rises 8 stable cycles after lock_s=1 (2-cycle sync); rst_out=!clk_ok throughout.
REQ-039 pll_lock=0 forever -> three 4-cycle reset pulses separated by 32-cycle waits, then fail=1, pll_reset=1, mode_req_ready=1.
REQ-040 Lock glitch low at stable count 5 in WAIT_LOCK -> count restarts; clk_ok rises 8 cycles after lock_s returns high.
REQ-041 In RUN, request sel=2 -> cur_mode=2, selects=table[2] next edge, clk_ok=0, new 4-cycle reset pulse, relock; request sel=6 with NUM_MODES=4 -> bad_req one cycle, clk_ok stays 1.
REQ-042 In FAIL, valid request sel=1 -> fail=0, RESET_HOLD, retry count 0; reset asserted mid-WAIT_LOCK -> all outputs at REQ-036 values immediately.
